// File: rtl/uart_rx_core.sv
// uart_rx_core - UART receiver with 16x oversampling.
//
// Frame format: 1 start bit, DATA_BITS data bits (LSB first), 1 even-parity bit,
// and STOP_BITS stop bits. The serial line is sampled in the middle of each bit.
// Each received byte is presented with its error flags over a valid/ack handshake.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   tick_rx    one-clock pulse at OVERSAMPLE x baud rate
//   rx_ack     consumer accepts rx_data (only honoured while rx_valid=1)
//   rx_data    last received byte
//   rx_valid   byte available, held until acknowledged
//   parity_err parity mismatch for the byte in rx_data
//   frame_err  a stop bit of that frame was sampled low
//   overrun    a frame completed while the previous byte was unacknowledged
//   rx_busy    receiver is not idle
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick_rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int SW = $clog2(STOP_BITS + 1);

  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [SW-1:0]          stop_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   perr_n;
  logic                   ferr_n;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   frame_done;

  // Even parity over the data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    even_parity = ^d;
  endfunction

  // Final stop-bit sample of a frame: the byte is delivered on this clock.
  assign frame_done = tick_rx && (state == STOP) && (cnt == CNT_END) && (stop_idx == LAST_STOP);

  // Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM, bit counters and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= '0;
      shift      <= '0;
      perr_n     <= 1'b0;
      ferr_n     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      // A new frame always overwrites the old byte; overrun flags that it was never taken.
      if (frame_done) begin
        rx_data    <= shift;
        parity_err <= perr_n;
        frame_err  <= ferr_n | ~rx_s;
        rx_valid   <= 1'b1;
        overrun    <= rx_valid & ~rx_ack;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      // Everything below advances only on oversampling ticks.
      if (tick_rx) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state   <= START;
              cnt     <= '0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (cnt == CNT_MID) begin
              if (rx_s) begin
                // Glitch: line back high by mid start bit.
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                // From here on, cnt wraps at the middle of each following bit.
                state   <= DATA;
                cnt     <= '0;
                bit_idx <= '0;
                ferr_n  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == CNT_END) begin
              // Right shift: the first (LSB) bit ends up in shift[0] after all samples.
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              cnt     <= '0;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == LAST_BIT) begin
                state <= PARITY;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            if (cnt == CNT_END) begin
              perr_n   <= rx_s ^ even_parity(shift);
              state    <= STOP;
              stop_idx <= '0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == CNT_END) begin
              cnt <= '0;
              if (stop_idx == LAST_STOP) begin
                // Deliver happens above; return to IDLE without waiting for the bit end.
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                ferr_n   <= ferr_n | ~rx_s;
                stop_idx <= stop_idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: directed and random frames, scoreboard-checked.
module tb_uart_rx_core;

  logic       clk     = 1'b0;
  logic       rst;
  logic       rx;
  logic       tick_rx = 1'b0;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t q[$];
  bit   auto_ack = 1'b1;
  bit   pending  = 1'b0;
  bit   ack_hi   = 1'b0;
  int   tick_div = 0;

  uart_rx_core #(.OVERSAMPLE(16), .DATA_BITS(8), .STOP_BITS(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tick_rx(tick_rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Oversampling tick: one clock in every three.
  always @(negedge clk) begin
    tick_div <= (tick_div == 2) ? 0 : tick_div + 1;
    tick_rx  <= (tick_div == 2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns #1 after the posedge on which the n-th tick is seen.
  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick_rx) c++;
    end
    #1;
  endtask

  task automatic set_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic s0,
                            input logic s1, input int gap, input logic ovr);
    exp_t e;
    e.data = d;
    e.perr = (par != ^d);
    e.ferr = !(s0 && s1);
    e.ovr  = ovr;
    q.push_back(e);
    set_bit(1'b0);
    for (int i = 0; i < 8; i++) set_bit(d[i]);
    set_bit(par);
    set_bit(s0);
    set_bit(s1);
    rx = 1'b1;
    if (gap > 0) wait_ticks(gap);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || pending || ack_hi) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got %0d outstanding frames expected 0", q.size());
    end
    wait_ticks(2);
  endtask

  // Monitor: detects deliveries, checks against the scoreboard, acknowledges.
  initial begin : monitor
    exp_t e;
    exp_t last;
    int   busy_cyc;
    bit   prev_busy;
    int   dly;
    busy_cyc  = 0;
    prev_busy = 1'b0;
    dly       = 0;
    rx_ack    = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_hi) begin
        rx_ack  = 1'b0;
        ack_hi  = 1'b0;
        pending = 1'b0;
        check("ack_valid", rx_valid, 0);
        check("ack_overrun", overrun, 0);
      end
      // A real frame keeps rx_busy high far longer than a rejected start bit.
      if (prev_busy && !rx_busy && busy_cyc > 100 && rx_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery: got data %0h expected no frame", rx_data);
        end else begin
          e = q.pop_front();
          check("data", rx_data, e.data);
          check("parity_err", parity_err, e.perr);
          check("frame_err", frame_err, e.ferr);
          check("overrun", overrun, e.ovr);
          last    = e;
          pending = 1'b1;
          dly     = $urandom_range(0, 6);
        end
      end else if (pending && auto_ack && !ack_hi) begin
        if (dly == 0) begin
          check("hold_valid", rx_valid, 1);
          check("hold_data", rx_data, last.data);
          check("hold_perr", parity_err, last.perr);
          check("hold_ferr", frame_err, last.ferr);
          rx_ack = 1'b1;
          ack_hi = 1'b1;
        end else begin
          dly--;
        end
      end
      if (rx_busy) busy_cyc++;
      else busy_cyc = 0;
      prev_busy = rx_busy;
    end
  end

  // Stimulus.
  initial begin : stim
    logic [7:0] d;
    logic       pflip;
    logic       s0;
    bit         seen;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", rx_busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(20);

    // Clean byte, parity error, stop-bit error (last stop low, long idle after).
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    wait_idle();
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    wait_idle();
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 24, 1'b0);
    wait_idle();

    // Short low pulse: busy for a while, no byte, then a normal frame.
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    check("glitch_busy_seen", seen, 1);
    check("glitch_no_valid", rx_valid, 0);
    check("glitch_idle", rx_busy, 0);
    wait_ticks(1);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    wait_idle();

    // Back-to-back frames without acknowledge.
    auto_ack = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 4, 1'b1);
    @(negedge clk);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", overrun, 1);
    check("ovr_data", rx_data, 8'hC3);
    auto_ack = 1'b1;
    wait_idle();

    // Reset in the middle of data bit 4 of 0xFF.
    set_bit(1'b0);
    for (int i = 0; i < 4; i++) set_bit(1'b1);
    rx = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_perr", parity_err, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", rx_busy, 0);
    rst = 1'b0;
    wait_ticks(20);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    wait_idle();

    // Random frames: occasional parity flips and first-stop-bit errors.
    for (int k = 0; k < 16; k++) begin
      d     = 8'($urandom);
      pflip = ($urandom_range(0, 3) == 0);
      s0    = ($urandom_range(0, 3) != 0);
      send_frame(d, (^d) ^ pflip, s0, 1'b1, $urandom_range(0, 4), 1'b0);
    end
    wait_idle();
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
